// File: rtl/semaforo_monitor_if.sv
// semaforo_monitor_if: colour-code bus from the light controller and lamp/fault status back from the monitor
interface semaforo_monitor_if;
    logic [1:0] color;
    logic [1:0] color2;
    logic       clr_fault;
    logic [2:0] lamp1;
    logic [2:0] lamp2;
    logic       fault;
    logic [2:0] fault_code;
    modport master (output color, color2, clr_fault, input lamp1, lamp2, fault, fault_code);
    modport slave (input color, color2, clr_fault, output lamp1, lamp2, fault, fault_code);
endinterface

// File: rtl/semaforo_monitor.sv
// semaforo_monitor: decodes two-head colour codes to lamp drives and latches the first safety fault into flashing yellow
module semaforo_monitor #(
    parameter int MAX_DWELL  = 20,
    parameter int MIN_YELLOW = 2,
    parameter int FLASH_DIV  = 4
) (
    input logic               clk,
    input logic               rst,
    semaforo_monitor_if.slave bus
);
    typedef enum logic [1:0] {INIT, RUN, FAULT} state_e;
    localparam logic [1:0] G = 2'b01, Y = 2'b10, R = 2'b11;

    state_e     state_q, state_d;
    logic [2:0] lamp1_q, lamp1_d, lamp2_q, lamp2_d, code_q, code_d, viol;
    logic [1:0] prev1_q, prev1_d, prev2_q, prev2_d;
    logic [7:0] dwell1_q, dwell1_d, dwell2_q, dwell2_d, flash_q, flash_d;
    logic       go_run, flash_wrap;

    function automatic logic [2:0] decode(input logic [1:0] c);
        return c == G ? 3'b001 : c == Y ? 3'b010 : c == R ? 3'b100 : 3'b000;
    endfunction

    function automatic logic [2:0] head_viol(input logic [1:0] c, input logic [1:0] p, input logic [7:0] d);
        logic ok;
        ok = c == p || (p == G && c == Y) || (p == Y && c == R) || (p == R && c == G);
        return !ok ? 3'd3 :
               (p == Y && c != Y && d < 8'(MIN_YELLOW)) ? 3'd4 :
               (c == p && {1'b0, d} + 9'd1 > 9'(MAX_DWELL)) ? 3'd5 : 3'd0;
    endfunction

    function automatic logic [2:0] min_nz(input logic [2:0] a, input logic [2:0] b);
        return a == 3'd0 ? b : b == 3'd0 ? a : (a < b ? a : b);
    endfunction

    function automatic logic [7:0] bump(input logic [1:0] c, input logic [1:0] p, input logic [7:0] d);
        return c != p ? 8'd1 : (d == 8'hff ? d : d + 8'd1);
    endfunction

    assign go_run = bus.color != 2'b00 && bus.color2 != 2'b00 && (bus.color == R || bus.color2 == R);
    assign flash_wrap = flash_q == 8'(FLASH_DIV - 1);
    // lower code wins; the two whole-bus checks pre-empt the per-head ones
    assign viol = (bus.color == 2'b00 || bus.color2 == 2'b00) ? 3'd1 :
                  (bus.color != R && bus.color2 != R) ? 3'd2 :
                  min_nz(head_viol(bus.color, prev1_q, dwell1_q), head_viol(bus.color2, prev2_q, dwell2_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= INIT;
            lamp1_q  <= 3'b100;
            lamp2_q  <= 3'b100;
            code_q   <= 3'd0;
            prev1_q  <= R;
            prev2_q  <= R;
            dwell1_q <= 8'd0;
            dwell2_q <= 8'd0;
            flash_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            lamp1_q  <= lamp1_d;
            lamp2_q  <= lamp2_d;
            code_q   <= code_d;
            prev1_q  <= prev1_d;
            prev2_q  <= prev2_d;
            dwell1_q <= dwell1_d;
            dwell2_q <= dwell2_d;
            flash_q  <= flash_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && go_run) state_d = RUN;
        else if (state_q == RUN && viol != 3'd0) state_d = FAULT;
        else if (state_q == FAULT && bus.clr_fault) state_d = INIT;
    end

    always_comb begin
        lamp1_d  = lamp1_q;
        lamp2_d  = lamp2_q;
        code_d   = code_q;
        prev1_d  = prev1_q;
        prev2_d  = prev2_q;
        dwell1_d = dwell1_q;
        dwell2_d = dwell2_q;
        flash_d  = flash_q;
        if (state_d == FAULT && state_q != FAULT) begin
            code_d  = viol;
            lamp1_d = 3'b010;
            lamp2_d = 3'b010;
            flash_d = 8'd0;
        end else if (state_d == FAULT) begin
            flash_d = flash_wrap ? 8'd0 : flash_q + 8'd1;
            lamp1_d = flash_wrap ? lamp1_q ^ 3'b010 : lamp1_q;
            lamp2_d = flash_wrap ? lamp2_q ^ 3'b010 : lamp2_q;
        end else if (state_d == RUN) begin
            lamp1_d  = decode(bus.color);
            lamp2_d  = decode(bus.color2);
            prev1_d  = bus.color;
            prev2_d  = bus.color2;
            dwell1_d = state_q == INIT ? 8'd1 : bump(bus.color, prev1_q, dwell1_q);
            dwell2_d = state_q == INIT ? 8'd1 : bump(bus.color2, prev2_q, dwell2_q);
        end else begin
            lamp1_d  = 3'b100;
            lamp2_d  = 3'b100;
            code_d   = 3'd0;
            dwell1_d = 8'd0;
            dwell2_d = 8'd0;
        end
    end

    assign bus.lamp1      = lamp1_q;
    assign bus.lamp2      = lamp2_q;
    assign bus.fault      = state_q == FAULT;
    assign bus.fault_code = code_q;
endmodule
